cache_line_ctrl: RTL and testbench
==================================

Name: cache_line_ctrl

Overview:
- Sequencing controller for the direct-mapped single-line-per-index cache storage block (tag/valid/dirty plus 8 data words per index).
- Accepts one CPU word request at a time and probes the line.
- On a miss, writes back a dirty victim line (8 words) and refills 8 words from memory, then replays the access.
- Sits between the CPU memory stage, the cache storage block and the memory/bus interface.

Parameters:
- OFFSET_WIDTH, 3: word-select bits; line = 1<<OFFSET_WIDTH words.
- INDEX_WIDTH, 7: index bits.
- TAG_WIDTH, 30-OFFSET_WIDTH-INDEX_WIDTH: tag bits (word address = tag|index|offset, plus byte bits [1:0]).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- cpu_req  in  1  request valid; held until cpu_ready.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  32  byte address; [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_byte_en  in  4  store byte enables.
- cpu_ready  out  1  request completes this cycle.
- cpu_rdata  out  32  load data, valid while cpu_ready.
- ln_enable  out  1  line access enable.
- ln_index  out  INDEX_WIDTH  line index.
- ln_word_sel  out  OFFSET_WIDTH  word select.
- ln_cmp  out  1  compare mode.
- ln_write  out  1  write strobe.
- ln_tag  out  TAG_WIDTH  tag in.
- ln_data  out  32  data in.
- ln_valid  out  1  valid in.
- ln_byte_w_en  out  4  byte enables.
- ln_hit  in  1  tag match.
- ln_dirty  in  1  dirty status.
- ln_tag_out  in  TAG_WIDTH  stored tag.
- ln_data_out  in  32  selected word; combinational read.
- ln_valid_out  in  1  valid status.
- mem_req  out  1  memory word request.
- mem_we  out  1  1=write.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion of current word.

Behaviour:
- Reset (rst==0 at edge):
  - State IDLE, word counter 0, request latches 0.
  - Every output 0 (cpu_ready, cpu_rdata, all ln_*, all mem_*).
  - Reset mid-writeback or mid-refill aborts immediately; mem_req drops the next cycle. The partial line is left as written.
- IDLE: ln_enable=0. On cpu_req, latch addr/we/wdata/byte_en into req_* and go to COMPARE.
- COMPARE: ln_enable=1, ln_cmp=1, ln_write=req_we, ln_tag/index/word_sel from req_addr, ln_data=req_wdata, ln_byte_w_en=req_byte_en.
  - Hit = ln_hit & ln_valid_out.
  - Hit: cpu_ready=1 this cycle, cpu_rdata=ln_data_out (loads), go to IDLE. A store hit writes the word and sets dirty in the same cycle. Hit latency = 2 cycles from cpu_req.
  - Miss with ln_valid_out & ln_dirty: go to WB, counter 0.
  - Miss otherwise: go to REFILL, counter 0.
- WB:
  - Line: ln_enable=1, cmp=0, write=0, word_sel=cnt.
  - Memory: mem_req=1, mem_we=1, mem_addr={ln_tag_out,index,cnt,2'b00}, mem_wdata=ln_data_out; address and data stable until mem_ack.
  - On mem_ack: cnt+1. Ack at cnt==7 goes to REFILL with cnt=0.
- REFILL:
  - Memory: mem_req=1, mem_we=0, mem_addr={req_tag,index,cnt,2'b00}.
  - Line: ln_write=1 only in the mem_ack cycle, with cmp=0, word_sel=cnt, ln_data=mem_rdata, ln_tag=req_tag, ln_valid=1, ln_byte_w_en=4'b1111 (dirty cleared).
  - Ack at cnt==7 goes to COMPARE, which replays the access and is guaranteed to hit.
- Counter wraps 7->0 exactly at the state change.
- mem_ack outside WB/REFILL is ignored.
- cpu_req changes while busy are ignored; the latched request is used throughout.

Optional Feature:
- CACHE_STATS_EN defined: outputs stat_hits[31:0] and stat_misses[31:0] are added.
  - Each COMPARE cycle increments exactly one of them; the replay COMPARE after a refill does not count.
  - Both are cleared by reset and wrap at 2^32.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package cache_pkg: OFFSET_WIDTH/INDEX_WIDTH/TAG_WIDTH defaults, the state encoding (IDLE, COMPARE, WB, REFILL), and address field slice constants.
- One natural sub-module: cache_stats (the counter pair), instantiated only under CACHE_STATS_EN.

Test Plan:
- Cold load to 0x0000_1040, mem_rdata=0xA000_0000+wordidx, ack 1 cycle after req:
  - 8 REFILL reads at 0x1040..0x105C.
  - cpu_ready with rdata 0xA000_0000.
  - Re-load of 0x1044 then hits in 2 cycles with 0xA000_0001.
- Store 0xDEADBEEF, byte_en 4'b0011, to cached 0x1048 (old word 0xA000_0002):
  - Hit in 2 cycles.
  - Subsequent load returns 0xA000_BEEF.
- Load 0x0008_1040 (same index, different tag) after the dirty store:
  - 8 WB writes to 0x1040..0x105C with 0x1048 carrying 0xA000_BEEF.
  - Then 8 refill reads at 0x81040..0x8105C.
- mem_ack delayed 5 cycles per word: mem_addr/mem_wdata stable throughout, no word skipped or duplicated.
- rst=0 during REFILL word 3:
  - Next cycle all outputs 0 and state IDLE.
  - A new request afterward misses and fully refills.
- CACHE_STATS_EN: sequence of 3 hits and 2 misses gives stat_hits=3, stat_misses=2.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache line controller: default geometry,
// controller state encoding and byte-address field positions.
package cache_pkg;

   localparam int DEF_OFFSET_WIDTH = 3;
   localparam int DEF_INDEX_WIDTH  = 7;
   localparam int DEF_TAG_WIDTH    = 30 - DEF_OFFSET_WIDTH - DEF_INDEX_WIDTH;

   // Byte-address field positions for the default geometry.
   localparam int BYTE_BITS      = 2;
   localparam int DEF_OFFSET_LSB = BYTE_BITS;
   localparam int DEF_INDEX_LSB  = DEF_OFFSET_LSB + DEF_OFFSET_WIDTH;
   localparam int DEF_TAG_LSB    = DEF_INDEX_LSB + DEF_INDEX_WIDTH;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      WB      = 2'd2,
      REFILL  = 2'd3
   } state_t;

endpackage

// File: rtl/cache_stats.sv
// Hit/miss counter pair for the cache line controller. Only present in
// builds that define CACHE_STATS_EN; counters wrap at 2^32.
`ifdef CACHE_STATS_EN
module cache_stats (
   input  logic        clk,
   input  logic        rst,
   input  logic        hit_pulse,
   input  logic        miss_pulse,
   output logic [31:0] stat_hits,
   output logic [31:0] stat_misses
);

   logic [31:0] count_reg [2];
   logic        pulse     [2];

   assign pulse[0] = hit_pulse;
   assign pulse[1] = miss_pulse;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         // One free-running counter per event class, cleared by reset.
         always_ff @(posedge clk) begin
            if (!rst) begin
               count_reg[gi] <= '0;
            end else if (pulse[gi]) begin
               count_reg[gi] <= count_reg[gi] + 32'd1;
            end
         end
      end
   endgenerate

   assign stat_hits   = count_reg[0];
   assign stat_misses = count_reg[1];

endmodule
`endif

// File: rtl/cache_line_ctrl.sv
// Sequencing controller for a direct-mapped cache line store: probes the
// line for one CPU request, writes back a dirty victim, refills the line
// word by word from memory and replays the access.
// Optional macro CACHE_STATS_EN adds stat_hits/stat_misses outputs.
module cache_line_ctrl
   import cache_pkg::*;
#(
   parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
   parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
   parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [31:0]             cpu_addr,
   input  logic [31:0]             cpu_wdata,
   input  logic [3:0]              cpu_byte_en,
   output logic                    cpu_ready,
   output logic [31:0]             cpu_rdata,
   output logic                    ln_enable,
   output logic [INDEX_WIDTH-1:0]  ln_index,
   output logic [OFFSET_WIDTH-1:0] ln_word_sel,
   output logic                    ln_cmp,
   output logic                    ln_write,
   output logic [TAG_WIDTH-1:0]    ln_tag,
   output logic [31:0]             ln_data,
   output logic                    ln_valid,
   output logic [3:0]              ln_byte_w_en,
   input  logic                    ln_hit,
   input  logic                    ln_dirty,
   input  logic [TAG_WIDTH-1:0]    ln_tag_out,
   input  logic [31:0]             ln_data_out,
   input  logic                    ln_valid_out,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [31:0]             mem_addr,
   output logic [31:0]             mem_wdata,
   input  logic [31:0]             mem_rdata,
   input  logic                    mem_ack
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]             stat_hits,
   output logic [31:0]             stat_misses
`endif
);

   localparam int OFF_LSB = BYTE_BITS;
   localparam int IDX_LSB = OFF_LSB + OFFSET_WIDTH;
   localparam int TAG_LSB = IDX_LSB + INDEX_WIDTH;
   localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

   state_t                  state_reg, state_next;
   logic [OFFSET_WIDTH-1:0] cnt_reg, cnt_next;
   logic [TAG_WIDTH-1:0]    req_tag_reg;
   logic [INDEX_WIDTH-1:0]  req_index_reg;
   logic [OFFSET_WIDTH-1:0] req_offset_reg;
   logic                    req_we_reg;
   logic [31:0]             req_wdata_reg;
   logic [3:0]              req_be_reg;
   logic                    probe_hit;
   logic                    unused_byte_bits;

   // Byte-select bits never matter: every access is a whole word.
   assign unused_byte_bits = ^cpu_addr[BYTE_BITS-1:0];
   assign probe_hit        = ln_hit & ln_valid_out;

   // State, word counter and the request latch (captured only in IDLE so
   // that later cpu_* wiggles cannot disturb an access in flight).
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         req_tag_reg    <= '0;
         req_index_reg  <= '0;
         req_offset_reg <= '0;
         req_we_reg     <= 1'b0;
         req_wdata_reg  <= '0;
         req_be_reg     <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == IDLE && cpu_req) begin
            req_tag_reg    <= cpu_addr[TAG_LSB +: TAG_WIDTH];
            req_index_reg  <= cpu_addr[IDX_LSB +: INDEX_WIDTH];
            req_offset_reg <= cpu_addr[OFF_LSB +: OFFSET_WIDTH];
            req_we_reg     <= cpu_we;
            req_wdata_reg  <= cpu_wdata;
            req_be_reg     <= cpu_byte_en;
         end
      end
   end

   // Next-state and output decode; outputs are all zero unless a state
   // drives them, so IDLE (and the cycle after reset) presents all zeros.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      cpu_ready    = 1'b0;
      cpu_rdata    = '0;
      ln_enable    = 1'b0;
      ln_index     = '0;
      ln_word_sel  = '0;
      ln_cmp       = 1'b0;
      ln_write     = 1'b0;
      ln_tag       = '0;
      ln_data      = '0;
      ln_valid     = 1'b0;
      ln_byte_w_en = '0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      case (state_reg)
         IDLE: begin
            if (cpu_req) begin
               state_next = COMPARE;
            end
         end
         COMPARE: begin
            ln_enable    = 1'b1;
            ln_cmp       = 1'b1;
            ln_write     = req_we_reg;
            ln_tag       = req_tag_reg;
            ln_index     = req_index_reg;
            ln_word_sel  = req_offset_reg;
            ln_data      = req_wdata_reg;
            ln_byte_w_en = req_be_reg;
            if (probe_hit) begin
               cpu_ready  = 1'b1;
               cpu_rdata  = req_we_reg ? 32'h0 : ln_data_out;
               state_next = IDLE;
            end else begin
               cnt_next   = '0;
               state_next = (ln_valid_out && ln_dirty) ? WB : REFILL;
            end
         end
         WB: begin
            ln_enable   = 1'b1;
            ln_index    = req_index_reg;
            ln_word_sel = cnt_reg;
            mem_req     = 1'b1;
            mem_we      = 1'b1;
            // Victim address comes from the stored tag, not the request.
            mem_addr    = {ln_tag_out, req_index_reg, cnt_reg, {BYTE_BITS{1'b0}}};
            mem_wdata   = ln_data_out;
            if (mem_ack) begin
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == LAST_WORD) begin
                  state_next = REFILL;
               end
            end
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {req_tag_reg, req_index_reg, cnt_reg, {BYTE_BITS{1'b0}}};
            if (mem_ack) begin
               ln_enable    = 1'b1;
               ln_write     = 1'b1;
               ln_index     = req_index_reg;
               ln_word_sel  = cnt_reg;
               ln_data      = mem_rdata;
               ln_tag       = req_tag_reg;
               ln_valid     = 1'b1;
               ln_byte_w_en = 4'b1111;
               cnt_next     = cnt_reg + 1'b1;
               if (cnt_reg == LAST_WORD) begin
                  state_next = COMPARE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef CACHE_STATS_EN
   logic replay_reg;
   logic probe_count;

   // Marks the COMPARE that replays an access after refill so it is not
   // counted a second time.
   always_ff @(posedge clk) begin
      if (!rst) begin
         replay_reg <= 1'b0;
      end else if (state_reg == REFILL && state_next == COMPARE) begin
         replay_reg <= 1'b1;
      end else if (state_reg == COMPARE) begin
         replay_reg <= 1'b0;
      end
   end

   assign probe_count = (state_reg == COMPARE) && !replay_reg;

   cache_stats u_stats (
      .clk         (clk),
      .rst         (rst),
      .hit_pulse   (probe_count && probe_hit),
      .miss_pulse  (probe_count && !probe_hit),
      .stat_hits   (stat_hits),
      .stat_misses (stat_misses)
   );
`endif

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Bench for cache_line_ctrl: models the line storage block and a
// variable-latency memory around the DUT, predicts CPU responses and
// memory traffic from an architectural memory view plus a line directory.
`timescale 1ns/1ps
module tb_cache_line_ctrl;
   import cache_pkg::*;

   localparam int TW = 20;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } mem_exp_t;

   typedef struct packed {
      logic        is_load;
      logic        exp_hit;
      logic [31:0] rdata;
      logic [31:0] issue;
      logic [31:0] addr;
   } cpu_exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [31:0]   cpu_addr = '0;
   logic [31:0]   cpu_wdata = '0;
   logic [3:0]    cpu_byte_en = '0;
   logic          cpu_ready;
   logic [31:0]   cpu_rdata;
   logic          ln_enable;
   logic [6:0]    ln_index;
   logic [2:0]    ln_word_sel;
   logic          ln_cmp;
   logic          ln_write;
   logic [TW-1:0] ln_tag;
   logic [31:0]   ln_data;
   logic          ln_valid;
   logic [3:0]    ln_byte_w_en;
   logic          ln_hit;
   logic          ln_dirty;
   logic [TW-1:0] ln_tag_out;
   logic [31:0]   ln_data_out;
   logic          ln_valid_out;
   logic          mem_req;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = '0;
   logic          mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
   logic [31:0]   stat_hits;
   logic [31:0]   stat_misses;
`endif

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int mem_delay = 1;
   int n_hit = 0;
   int n_miss = 0;

   mem_exp_t exp_mem[$];
   cpu_exp_t exp_cpu[$];

   logic [31:0] bmem    [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic          dir_valid [128];
   logic          dir_dirty [128];
   logic [TW-1:0] dir_tag   [128];

   cache_line_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .ln_enable(ln_enable), .ln_index(ln_index), .ln_word_sel(ln_word_sel),
      .ln_cmp(ln_cmp), .ln_write(ln_write), .ln_tag(ln_tag), .ln_data(ln_data),
      .ln_valid(ln_valid), .ln_byte_w_en(ln_byte_w_en),
      .ln_hit(ln_hit), .ln_dirty(ln_dirty), .ln_tag_out(ln_tag_out),
      .ln_data_out(ln_data_out), .ln_valid_out(ln_valid_out),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // Power-on memory contents; low region matches the directed scenario.
   function automatic logic [31:0] init_val(input logic [31:0] a);
      if (a[31:13] == 19'd0) return 32'hA000_0000 + {29'd0, a[4:2]};
      return {a[31:2], 2'b01} ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] bread(input logic [31:0] a);
      if (bmem.exists(a)) return bmem[a];
      return init_val(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_val(a);
   endfunction

   // ---------------- line storage block model ----------------
   logic [TW-1:0] s_tag   [128]  = '{default: '0};
   logic          s_valid [128]  = '{default: 1'b0};
   logic          s_dirty [128]  = '{default: 1'b0};
   logic [31:0]   s_data  [1024] = '{default: 32'h0};

   assign ln_tag_out   = s_tag[ln_index];
   assign ln_valid_out = s_valid[ln_index];
   assign ln_dirty     = s_dirty[ln_index];
   assign ln_hit       = (s_tag[ln_index] == ln_tag);
   assign ln_data_out  = s_data[{ln_index, ln_word_sel}];

   always @(posedge clk) begin
      if (ln_enable && ln_write) begin
         if (ln_cmp) begin
            if (ln_hit && ln_valid_out) begin
               s_data[{ln_index, ln_word_sel}] <= merge(ln_data_out, ln_data, ln_byte_w_en);
               s_dirty[ln_index] <= 1'b1;
            end
         end else begin
            s_data[{ln_index, ln_word_sel}] <= merge(ln_data_out, ln_data, ln_byte_w_en);
            s_tag[ln_index]   <= ln_tag;
            s_valid[ln_index] <= ln_valid;
            s_dirty[ln_index] <= 1'b0;
         end
      end
   end

   // ---------------- CPU monitor + memory responder ----------------
   logic        m_busy = 1'b0;
   logic        m_moved = 1'b0;
   int          m_wait = 0;
   logic        m_we = 1'b0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_wd = '0;

   always @(negedge clk) begin
      cpu_exp_t ce;
      mem_exp_t me;
      int lat;
      if (rst && cpu_ready) begin
         tests++;
         if (exp_cpu.size() == 0) begin
            fails++;
            $display("FAIL cpu_unexpected_ready got=1 want=0");
         end else begin
            ce  = exp_cpu.pop_front();
            lat = cyc - int'(ce.issue);
            if ((lat == 1) != ce.exp_hit) begin
               fails++;
               $display("FAIL cpu_hit_latency addr=%h got=%0d cycles want_hit=%0b", ce.addr, lat, ce.exp_hit);
            end
            if (ce.is_load) begin
               tests++;
               if (cpu_rdata !== ce.rdata) begin
                  fails++;
                  $display("FAIL cpu_rdata addr=%h got=%h want=%h", ce.addr, cpu_rdata, ce.rdata);
               end
            end
            $display("[TB] cpu %s addr=%h rdata=%h latency=%0d", ce.is_load ? "load " : "store", ce.addr, cpu_rdata, lat);
         end
      end

      if (mem_ack) begin
         mem_ack = 1'b0;
         m_busy  = 1'b0;
      end
      if (m_busy && !mem_req) m_busy = 1'b0;
      if (!m_busy && mem_req) begin
         m_busy  = 1'b1;
         m_wait  = mem_delay;
         m_addr  = mem_addr;
         m_we    = mem_we;
         m_wd    = mem_wdata;
         m_moved = 1'b0;
      end else if (m_busy && (mem_addr !== m_addr || mem_we !== m_we || (m_we && mem_wdata !== m_wd))) begin
         m_moved = 1'b1;
      end
      if (m_busy) begin
         if (m_wait == 0) begin
            mem_ack = 1'b1;
            if (m_we) bmem[m_addr] = m_wd;
            else      mem_rdata = bread(m_addr);
            tests++;
            if (m_moved) begin
               fails++;
               $display("FAIL mem_stable addr=%h got=moved want=stable", m_addr);
            end
            tests++;
            if (exp_mem.size() == 0) begin
               fails++;
               $display("FAIL mem_unexpected got we=%0b addr=%h want=none", m_we, m_addr);
            end else begin
               me = exp_mem.pop_front();
               if (me.we !== m_we || me.addr !== m_addr || (m_we && me.data !== m_wd)) begin
                  fails++;
                  $display("FAIL mem_xfer got we=%0b addr=%h data=%h want we=%0b addr=%h data=%h",
                           m_we, m_addr, m_wd, me.we, me.addr, me.data);
               end
            end
         end else begin
            m_wait--;
         end
      end
   end

   // ---------------- stimulus + reference model ----------------
   task automatic issue_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be);
      logic [6:0]    idx;
      logic [TW-1:0] tag;
      logic [31:0]   wa;
      logic          hit;
      cpu_exp_t      e;
      idx = addr[11:5];
      tag = addr[31:12];
      wa  = {addr[31:2], 2'b00};
      hit = dir_valid[idx] && (dir_tag[idx] == tag);
      if (hit) begin
         n_hit++;
      end else begin
         n_miss++;
         if (dir_valid[idx] && dir_dirty[idx]) begin
            for (int w = 0; w < 8; w++) begin
               logic [31:0] va;
               va = {dir_tag[idx], idx, w[2:0], 2'b00};
               exp_mem.push_back('{1'b1, va, ref_rd(va)});
            end
         end
         for (int w = 0; w < 8; w++) begin
            logic [31:0] ra;
            ra = {tag, idx, w[2:0], 2'b00};
            exp_mem.push_back('{1'b0, ra, 32'h0});
         end
         dir_valid[idx] = 1'b1;
         dir_tag[idx]   = tag;
         dir_dirty[idx] = 1'b0;
      end
      if (we) begin
         ref_mem[wa]    = merge(ref_rd(wa), wd, be);
         dir_dirty[idx] = 1'b1;
      end
      e.is_load = !we;
      e.exp_hit = hit;
      e.rdata   = we ? 32'h0 : ref_rd(wa);
      e.issue   = cyc;
      e.addr    = addr;
      exp_cpu.push_back(e);
      cpu_req     = 1'b1;
      cpu_we      = we;
      cpu_addr    = addr;
      cpu_wdata   = wd;
      cpu_byte_en = be;
   endtask

   task automatic finish_run();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
      logic ok;
      issue_req(we, addr, wd, be);
      ok = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (cpu_ready) begin
            ok = 1'b1;
            break;
         end
         // Busy: the latched request must be used, so scramble the inputs.
         cpu_addr    = $urandom;
         cpu_wdata   = $urandom;
         cpu_we      = 1'($urandom_range(0, 1));
         cpu_byte_en = 4'($urandom_range(0, 15));
      end
      cpu_req = 1'b0;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL cpu_timeout addr=%h got=no_ready want=ready", addr);
         finish_run();
      end
      @(negedge clk);
   endtask

   task automatic check_quiet(input string name);
      tests++;
      if ((|{cpu_ready, cpu_rdata, ln_enable, ln_index, ln_word_sel, ln_cmp, ln_write, ln_tag,
             ln_data, ln_valid, ln_byte_w_en, mem_req, mem_we, mem_addr, mem_wdata}) !== 1'b0) begin
         fails++;
         $display("FAIL %s_outputs got=nonzero mem_req=%0b mem_addr=%h ln_enable=%0b want=all_zero",
                  name, mem_req, mem_addr, ln_enable);
      end
      tests++;
      if (dut.state_reg !== IDLE) begin
         fails++;
         $display("FAIL %s_state got=%0d want=%0d", name, dut.state_reg, IDLE);
      end
      $display("[TB] %s check done", name);
   endtask

   initial begin
      logic found;
      logic [19:0] tags [4];
      logic [6:0]  idxs [3];
      tags = '{20'h00001, 20'h00002, 20'h00003, 20'h00081};
      idxs = '{7'd2, 7'd5, 7'd127};
      for (int i = 0; i < 128; i++) begin
         dir_valid[i] = 1'b0;
         dir_dirty[i] = 1'b0;
         dir_tag[i]   = '0;
      end

      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst = 1'b1;
      @(negedge clk);

      // Abort a cold refill at word 3 with reset.
      mem_delay = 1;
      issue_req(1'b0, 32'h0007_0040, 32'h0, 4'h0);
      found = 1'b0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (mem_req && !mem_we && mem_addr[4:2] == 3'd3) begin
            found = 1'b1;
            break;
         end
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL reset_reach_word3 got=not_seen want=seen");
      end
      rst     = 1'b0;
      cpu_req = 1'b0;
      @(negedge clk);
      check_quiet("abort");
      rst = 1'b1;
      exp_cpu.delete();
      exp_mem.delete();
      n_hit  = 0;
      n_miss = 0;
      @(negedge clk);

      // Directed scenario around index 2.
      do_req(1'b0, 32'h0000_1040, 32'h0, 4'h0);
      do_req(1'b0, 32'h0000_1044, 32'h0, 4'h0);
      do_req(1'b1, 32'h0000_1048, 32'hDEAD_BEEF, 4'b0011);
      do_req(1'b0, 32'h0000_1048, 32'h0, 4'h0);
      do_req(1'b0, 32'h0008_1040, 32'h0, 4'h0);
      mem_delay = 5;
      do_req(1'b0, 32'h0000_1040, 32'h0, 4'h0);
      do_req(1'b1, 32'h0000_105C, 32'h1234_5678, 4'b1111);
      do_req(1'b0, 32'h0008_1044, 32'h0, 4'h0);

      // Randomized traffic over a few conflicting tags and indices.
      for (int t = 0; t < 80; t++) begin
         logic [31:0] a;
         mem_delay = $urandom_range(0, 3);
         a = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 2)], 3'($urandom_range(0, 7)), 2'b00};
         if ($urandom_range(0, 9) < 4) do_req(1'b1, a, $urandom, 4'($urandom_range(1, 15)));
         else                          do_req(1'b0, a, 32'h0, 4'h0);
      end

      repeat (2) @(negedge clk);
      tests++;
      if (exp_mem.size() != 0 || exp_cpu.size() != 0) begin
         fails++;
         $display("FAIL leftover_expect got mem=%0d cpu=%0d want 0/0", exp_mem.size(), exp_cpu.size());
      end
`ifdef CACHE_STATS_EN
      tests++;
      if (stat_hits !== 32'(n_hit) || stat_misses !== 32'(n_miss)) begin
         fails++;
         $display("FAIL stats got hits=%0d misses=%0d want hits=%0d misses=%0d",
                  stat_hits, stat_misses, n_hit, n_miss);
      end
`endif
      finish_run();
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "time limit");
   end

endmodule
